pipe_stage_skid: RTL and testbench



---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_entry_reg.sv | 27 ++
 rtl/pipe_stage_skid.sv | 168 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the parametrised pipeline stage register.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipe_pkg;

    // Occupancy of the stage: nothing held, main entry only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // Default geometry of a decode-to-execute entry.
    localparam int D_SIZE_DEF  = 32;
    localparam int OPC_W_DEF   = 7;
    localparam int DST_W_DEF   = 3;
    localparam int N_OPS_DEF   = 2;

    // Opcode that downstream decoders treat as "do nothing".
    localparam int NOP_OPC_DEF = 0;

    // Payload layout at the default geometry. The stage builds the same layout
    // from its own parameters so that other widths keep identical field order.
    typedef struct packed {
        logic [OPC_W_DEF-1:0]            opcode;
        logic [DST_W_DEF-1:0]            destination;
        logic [N_OPS_DEF*D_SIZE_DEF-1:0] operands;
    } pipe_payload_t;

    // Number of valid entries held (0, 1 or 2).
    function automatic logic [1:0] entry_count(input logic main_vld, input logic skid_vld);
        return {1'b0, main_vld} + {1'b0, skid_vld};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload-plus-valid holding register with load and clear.
// Latency: 1 cycle from load to q/vld.
// Backpressure: none; the owner decides when to load or clear.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    // Clear wipes the payload too, so a dropped entry leaves no stale data behind.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid so that in_ready is a pure register decode.
// Latency: 1 cycle from accepted input to out_valid; 1 entry/cycle while not halted.
// Backpressure: halt stalls the output; in_ready drops once the skid entry is occupied.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 D_SIZE          = D_SIZE_DEF,
    parameter int                 OPC_W           = OPC_W_DEF,
    parameter int                 DST_W           = DST_W_DEF,
    parameter int                 N_OPS           = N_OPS_DEF,
    parameter logic [OPC_W-1:0]   NOP_OPC         = OPC_W'(NOP_OPC_DEF),
    parameter bit                 FLUSH_OVER_HALT = 1'b1,
    parameter int                 CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    bubble,
    input  logic [OPC_W-1:0]        in_opcode,
    input  logic [DST_W-1:0]        in_destination,
    input  logic [N_OPS*D_SIZE-1:0] in_operands,
    input  logic                    halt,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [OPC_W-1:0]        out_opcode,
    output logic [DST_W-1:0]        out_destination,
    output logic [N_OPS*D_SIZE-1:0] out_operands,
    output logic [CNT_W-1:0]        flush_drops
);

    typedef struct packed {
        logic [OPC_W-1:0]        opcode;
        logic [DST_W-1:0]        destination;
        logic [N_OPS*D_SIZE-1:0] operands;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);

    pipe_state_t state;
    pipe_state_t state_nxt;

    payload_t in_pay;
    payload_t main_d;
    payload_t main_q;
    payload_t skid_q;
    logic     main_vld;
    logic     skid_vld;
    logic     main_load;
    logic     main_clr;
    logic     skid_load;
    logic     skid_clr;

    logic     halt_eff;
    logic     flush_eff;
    logic     accept;
    logic     out_fire;

    logic [CNT_W:0] drop_sum;

    assign in_pay = '{opcode: in_opcode, destination: in_destination, operands: in_operands};

    // Flush either wins outright or, when halt has priority, is deferred until halt drops.
    assign flush_eff = flush & (FLUSH_OVER_HALT | ~halt);
    assign halt_eff  = FLUSH_OVER_HALT ? (halt & ~flush) : halt;

    assign in_ready  = (state != SKID);
    assign out_valid = main_vld;
    assign out_fire  = main_vld & ~halt_eff;

    // Any asserted flush blocks acceptance: an effective flush discards the cycle's
    // input, and a deferred flush is a complete hold so nothing may slip into the skid.
    assign accept    = in_valid & ~bubble & in_ready & ~flush;

    // Next-state and entry-register controls; skid always drains into main so order stays FIFO.
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_d    = in_pay;
        if (flush_eff) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (accept && out_fire) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = SKID;
                    end else if (out_fire) begin
                        main_clr  = 1'b1;
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_d    = skid_q;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_nxt = FULL;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Occupancy register; in_ready is decoded from this alone, so halt never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    pipe_entry_reg #(.W(PAY_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .vld   (main_vld),
        .q     (main_q)
    );

    pipe_entry_reg #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_pay),
        .vld   (skid_vld),
        .q     (skid_q)
    );

    assign drop_sum = {1'b0, flush_drops} + (CNT_W+1)'(entry_count(main_vld, skid_vld));

    // Saturating count of valid entries thrown away by flush; reset discards are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_drops <= '0;
        end else if (flush_eff) begin
            flush_drops <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    // An empty stage presents a canonical NOP so consumers need not look at out_valid.
    assign out_opcode      = main_vld ? main_q.opcode      : NOP_OPC;
    assign out_destination = main_vld ? main_q.destination : '0;
    assign out_operands    = main_vld ? main_q.operands    : '0;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        bubble;
    logic [6:0]  in_opcode;
    logic [2:0]  in_destination;
    logic [63:0] in_operands;
    logic        halt;
    logic        flush;

    // default instance: FLUSH_OVER_HALT=1, CNT_W=8
    logic        in_ready, out_valid;
    logic [6:0]  out_opcode;
    logic [2:0]  out_destination;
    logic [63:0] out_operands;
    logic [7:0]  flush_drops;

    // halt-over-flush instance
    logic        f_in_ready, f_out_valid;
    logic [6:0]  f_out_opcode;
    logic [2:0]  f_out_destination;
    logic [63:0] f_out_operands;
    logic [7:0]  f_flush_drops;

    // narrow-counter instance
    logic        c_in_ready, c_out_valid;
    logic [6:0]  c_out_opcode;
    logic [2:0]  c_out_destination;
    logic [63:0] c_out_operands;
    logic [1:0]  c_flush_drops;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_skid u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bubble(bubble),
        .in_opcode(in_opcode), .in_destination(in_destination), .in_operands(in_operands),
        .halt(halt), .flush(flush), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_destination(out_destination), .out_operands(out_operands), .flush_drops(flush_drops)
    );

    pipe_stage_skid #(.FLUSH_OVER_HALT(1'b0)) u_foh0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready), .bubble(bubble),
        .in_opcode(in_opcode), .in_destination(in_destination), .in_operands(in_operands),
        .halt(halt), .flush(flush), .out_valid(f_out_valid), .out_opcode(f_out_opcode),
        .out_destination(f_out_destination), .out_operands(f_out_operands), .flush_drops(f_flush_drops)
    );

    pipe_stage_skid #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .bubble(bubble),
        .in_opcode(in_opcode), .in_destination(in_destination), .in_operands(in_operands),
        .halt(halt), .flush(flush), .out_valid(c_out_valid), .out_opcode(c_out_opcode),
        .out_destination(c_out_destination), .out_operands(c_out_operands), .flush_drops(c_flush_drops)
    );

    // advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; bubble = 1'b0; halt = 1'b0; flush = 1'b0;
        in_opcode = '0; in_destination = '0; in_operands = '0;
    endtask

    // stimulus only: leaves all instances holding a (main) and b (skid) with halt=1
    task automatic fill_skid(input logic [6:0] a, input logic [6:0] b);
        in_valid = 1'b1; halt = 1'b0; in_opcode = a; in_destination = 3'd1; in_operands = 64'h11;
        step();
        halt = 1'b1; in_opcode = b; in_destination = 3'd2; in_operands = 64'h22;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        tests++; if (out_opcode !== 7'd0) begin fails++; $display("FAIL reset_out_opcode got=%0d exp=0", out_opcode); end
        tests++; if (out_destination !== 3'd0 || out_operands !== 64'd0) begin fails++;
            $display("FAIL reset_payload got dst=%0d ops=%h exp 0/0", out_destination, out_operands); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        tests++; if (flush_drops !== 8'd0) begin fails++; $display("FAIL reset_flush_drops got=%0d exp=0", flush_drops); end
    endtask

    task automatic test_stream();
        logic [63:0] exp_ops;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_opcode = 7'(i);
            in_destination = 3'(i);
            in_operands = {32'(2*i + 1), 32'(2*i)};
            exp_ops = {32'(2*i + 1), 32'(2*i)};
            step();
            tests++; if (out_valid !== 1'b1 || out_opcode !== 7'(i)) begin fails++;
                $display("FAIL stream_out[%0d] got vld=%0b opc=%0d exp vld=1 opc=%0d", i, out_valid, out_opcode, i); end
            tests++; if (out_destination !== 3'(i) || out_operands !== exp_ops) begin fails++;
                $display("FAIL stream_payload[%0d] got dst=%0d ops=%h exp dst=%0d ops=%h", i, out_destination, out_operands, i, exp_ops); end
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        tests++; if (out_valid !== 1'b0 || out_opcode !== 7'd0 || out_operands !== 64'd0) begin fails++;
            $display("FAIL stream_drain got vld=%0b opc=%0d ops=%h exp 0/0/0", out_valid, out_opcode, out_operands); end
    endtask

    task automatic test_halt_skid();
        in_valid = 1'b1; in_opcode = 7'd9; in_destination = 3'd3; in_operands = 64'h9;
        step();
        tests++; if (out_opcode !== 7'd9 || in_ready !== 1'b1) begin fails++;
            $display("FAIL halt_first_accept got opc=%0d rdy=%0b exp 9/1", out_opcode, in_ready); end
        // first halted cycle: 10 is accepted into the skid
        halt = 1'b1; in_opcode = 7'd10; in_destination = 3'd4; in_operands = 64'hA;
        step();
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || out_opcode !== 7'd9 || out_valid !== 1'b1) begin fails++;
            $display("FAIL halt_cycle2 got rdy=%0b vld=%0b opc=%0d exp 0/1/9", in_ready, out_valid, out_opcode); end
        step();
        tests++; if (in_ready !== 1'b0 || out_opcode !== 7'd9) begin fails++;
            $display("FAIL halt_cycle3 got rdy=%0b opc=%0d exp 0/9", in_ready, out_opcode); end
        step();
        tests++; if (in_ready !== 1'b0 || out_opcode !== 7'd9 || out_destination !== 3'd3) begin fails++;
            $display("FAIL halt_hold got rdy=%0b opc=%0d dst=%0d exp 0/9/3", in_ready, out_opcode, out_destination); end
        halt = 1'b0;
        step();
        tests++; if (out_valid !== 1'b1 || out_opcode !== 7'd10 || out_destination !== 3'd4 || out_operands !== 64'hA) begin fails++;
            $display("FAIL halt_release got vld=%0b opc=%0d dst=%0d ops=%h exp 1/10/4/a", out_valid, out_opcode, out_destination, out_operands); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL halt_release_rdy got=%0b exp=1", in_ready); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL halt_drain got vld=%0b exp=0", out_valid); end
    endtask

    task automatic test_bubble();
        in_valid = 1'b1; bubble = 1'b1; in_opcode = 7'd7; in_destination = 3'd5; in_operands = 64'h77;
        step();
        in_valid = 1'b0; bubble = 1'b0;
        tests++; if (out_valid !== 1'b0 || out_opcode !== 7'd0 || out_destination !== 3'd0) begin fails++;
            $display("FAIL bubble got vld=%0b opc=%0d dst=%0d exp 0/0/0", out_valid, out_opcode, out_destination); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_rdy got=%0b exp=1", in_ready); end
    endtask

    task automatic test_flush_priority();
        fill_skid(7'd20, 7'd21);
        flush = 1'b1;   // halt still 1
        step();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_opcode !== 7'd0) begin fails++;
            $display("FAIL flush_over_halt got vld=%0b rdy=%0b opc=%0d exp 0/1/0", out_valid, in_ready, out_opcode); end
        tests++; if (flush_drops !== 8'd2) begin fails++; $display("FAIL flush_over_halt_drops got=%0d exp=2", flush_drops); end
        tests++; if (f_out_valid !== 1'b1 || f_out_opcode !== 7'd20 || f_in_ready !== 1'b0) begin fails++;
            $display("FAIL halt_over_flush_hold got vld=%0b opc=%0d rdy=%0b exp 1/20/0", f_out_valid, f_out_opcode, f_in_ready); end
        tests++; if (f_flush_drops !== 8'd0) begin fails++; $display("FAIL halt_over_flush_drops got=%0d exp=0", f_flush_drops); end
        // halt released with flush still asserted: the deferred flush now takes effect
        halt = 1'b0;
        step();
        flush = 1'b0;
        tests++; if (f_out_valid !== 1'b0 || f_in_ready !== 1'b1 || f_flush_drops !== 8'd2) begin fails++;
            $display("FAIL deferred_flush got vld=%0b rdy=%0b drops=%0d exp 0/1/2", f_out_valid, f_in_ready, f_flush_drops); end
        tests++; if (flush_drops !== 8'd2) begin fails++; $display("FAIL empty_flush_drops got=%0d exp=2", flush_drops); end
    endtask

    task automatic test_reset_mid();
        fill_skid(7'd30, 7'd31);
        rst = 1'b1;
        step();
        rst = 1'b0; halt = 1'b0;
        tests++; if (out_valid !== 1'b0 || out_opcode !== 7'd0 || out_operands !== 64'd0) begin fails++;
            $display("FAIL rst_mid_out got vld=%0b opc=%0d ops=%h exp 0/0/0", out_valid, out_opcode, out_operands); end
        tests++; if (in_ready !== 1'b1 || flush_drops !== 8'd0) begin fails++;
            $display("FAIL rst_mid_ctrl got rdy=%0b drops=%0d exp 1/0", in_ready, flush_drops); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_skid_gone got vld=%0b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [3];
        logic [7:0] exp_d [3];
        exp_c[0] = 2'd2; exp_c[1] = 2'd3; exp_c[2] = 2'd3;
        exp_d[0] = 8'd2; exp_d[1] = 8'd4; exp_d[2] = 8'd6;
        for (int k = 0; k < 3; k++) begin
            fill_skid(7'(40 + 2*k), 7'(41 + 2*k));
            halt = 1'b0; flush = 1'b1;
            step();
            flush = 1'b0;
            tests++; if (c_flush_drops !== exp_c[k]) begin fails++;
                $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, c_flush_drops, exp_c[k]); end
            tests++; if (flush_drops !== exp_d[k]) begin fails++;
                $display("FAIL wide_cnt[%0d] got=%0d exp=%0d", k, flush_drops, exp_d[k]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_stream();
        test_halt_skid();
        test_bubble();
        test_flush_priority();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
